// File: rtl/fcc_rd_arb_pkg.sv
// Shared types and default widths for the FCC memory read-port arbiter.
// The client indices are fixed by how fcc wires its three read channels.
package fcc_rd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } rd_arb_state_e;

    localparam int CL_PIC  = 0;
    localparam int CL_WGT  = 1;
    localparam int CL_BIAS = 2;

    localparam int DEF_N_CLIENTS      = 3;
    localparam int DEF_ADDR_WIDTH     = 19;
    localparam int DEF_MAX_BYTES_TO_RD = 32;
    localparam int DEF_DATA_W         = 256;
    localparam int DEF_LV_W           = $clog2(DEF_DATA_W / 8);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot winner at or after ptr, wrapping.
// Written generically so the write-port sharing logic can reuse it.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [PW-1:0]  off;
    logic [PW:0]    win;

    always_comb begin
        dbl     = {req, req} >> ptr;
        rot     = dbl[N-1:0];
        off     = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!gnt_any && rot[i]) begin
                gnt_any = 1'b1;
                off     = PW'(i);
            end
        end
        // Undo the rotation: winner = ptr + offset, modulo N.
        win = {1'b0, ptr} + {1'b0, off};
        if (win >= (PW + 1)'(N)) begin
            win = win - (PW + 1)'(N);
        end
        gnt_idx = win[PW-1:0];
        gnt     = gnt_any ? (N'(1) << win) : '0;
    end

endmodule

// File: rtl/fcc_mem_rd_arb.sv
// Shares the single memory read port among the FCC pic/wgt/bias requesters,
// round-robin, holding the grant until the memory's last beat.
//
//   state | meaning
//   IDLE  | no owner; arbitrate cl_req, beats seen here are unexpected
//   REQ   | grant held, mem_req high until the first returned beat
//   DATA  | grant held, routing beats until mem_last
module fcc_mem_rd_arb
    import fcc_rd_arb_pkg::*;
#(
    parameter int N_CLIENTS       = DEF_N_CLIENTS,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int MAX_BYTES_TO_RD = DEF_MAX_BYTES_TO_RD,
    parameter int SIZE_W          = $clog2(MAX_BYTES_TO_RD) + 1,
    parameter int DATA_W          = DEF_DATA_W,
    parameter int LV_W            = $clog2(DATA_W / 8)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [N_CLIENTS-1:0]                  cl_req,
    input  logic [N_CLIENTS-1:0][ADDR_WIDTH-1:0]  cl_start_addr,
    input  logic [N_CLIENTS-1:0][SIZE_W-1:0]      cl_size_bytes,
    output logic [N_CLIENTS-1:0]                  cl_valid,
    output logic [N_CLIENTS-1:0]                  cl_last,
    output logic [DATA_W-1:0]                     cl_data,
    output logic [LV_W-1:0]                       cl_last_valid,
    output logic                                  mem_req,
    output logic [ADDR_WIDTH-1:0]                 mem_start_addr,
    output logic [SIZE_W-1:0]                     mem_size_bytes,
    input  logic                                  mem_valid,
    input  logic                                  mem_last,
    input  logic [DATA_W-1:0]                     mem_data,
    input  logic [LV_W-1:0]                       mem_last_valid,
    output logic [N_CLIENTS-1:0]                  grant,
    output logic                                  busy,
    output logic                                  err_unexp_valid
);

    localparam int PW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

    rd_arb_state_e          state_q, state_d;
    logic [N_CLIENTS-1:0]   grant_q, grant_d;
    logic [PW-1:0]          gidx_q, gidx_d;
    logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
    logic                   mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [SIZE_W-1:0]      size_q, size_d;
    logic                   err_q, err_d;

    logic [N_CLIENTS-1:0]   arb_gnt;
    logic [PW-1:0]          arb_idx;
    logic                   arb_any;
    logic                   rel_grant;

    rr_arbiter #(
        .N  (N_CLIENTS),
        .PW (PW)
    ) u_rr_arbiter (
        .req     (cl_req),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        rr_ptr_d  = rr_ptr_q;
        mem_req_d = mem_req_q;
        addr_d    = addr_q;
        size_d    = size_q;
        err_d     = err_q;
        rel_grant = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    err_d = 1'b1;
                end
                if (arb_any) begin
                    grant_d   = arb_gnt;
                    gidx_d    = arb_idx;
                    addr_d    = cl_start_addr[arb_idx];
                    size_d    = cl_size_bytes[arb_idx];
                    mem_req_d = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (mem_valid) begin
                    mem_req_d = 1'b0;
                    if (mem_last) begin
                        rel_grant = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (mem_valid && mem_last) begin
                    rel_grant = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Returning to IDLE forces a one-cycle bubble before the next grant.
        if (rel_grant) begin
            state_d   = IDLE;
            grant_d   = '0;
            mem_req_d = 1'b0;
            rr_ptr_d  = (gidx_q == PW'(N_CLIENTS - 1)) ? '0 : PW'(gidx_q + PW'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            rr_ptr_q  <= PW'(CL_PIC);
            mem_req_q <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            rr_ptr_q  <= rr_ptr_d;
            mem_req_q <= mem_req_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            err_q     <= err_d;
        end
    end

    assign cl_valid        = {N_CLIENTS{mem_valid}} & grant_q;
    assign cl_last         = {N_CLIENTS{mem_valid & mem_last}} & grant_q;
    assign cl_data         = mem_data;
    assign cl_last_valid   = mem_last_valid;
    assign mem_req         = mem_req_q;
    assign mem_start_addr  = addr_q;
    assign mem_size_bytes  = size_q;
    assign grant           = grant_q;
    assign busy            = (state_q != IDLE);
    assign err_unexp_valid = err_q;

endmodule
